gmux_4way_16: RTL and testbench



---
 rtl/gmux_4way_16.sv | 64 ++++++
 tb/tb_gmux_4way_16.sv | 130 +++++++++++++
 2 files changed

// File: rtl/gmux_4way_16.sv
// 4-way word multiplexer built from gate-level 2-way mux cells.
// The combinational select drives y; a registered copy is kept on y_q.
module gmux_4way_16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  input  logic             clk,
  input  logic             rst_n
);

  logic ns0;
  logic ns1;

  not u_ns0 (ns0, sel[0]);
  not u_ns1 (ns1, sel[1]);

  // Per-bit mux tree: (a,b) and (c,d) on sel[0], then the pair on sel[1].
  // Each cell adds the x&y consensus term so agreeing inputs stay resolved
  // when the select is unknown; it is logically redundant otherwise.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic lo;
    logic hi;
    logic lo_a;
    logic lo_b;
    logic lo_k;
    logic hi_c;
    logic hi_d;
    logic hi_k;
    logic out_l;
    logic out_h;
    logic out_k;

    and u_lo_a (lo_a, a[i], ns0);
    and u_lo_b (lo_b, b[i], sel[0]);
    and u_lo_k (lo_k, a[i], b[i]);
    or  u_lo   (lo, lo_a, lo_b, lo_k);

    and u_hi_c (hi_c, c[i], ns0);
    and u_hi_d (hi_d, d[i], sel[0]);
    and u_hi_k (hi_k, c[i], d[i]);
    or  u_hi   (hi, hi_c, hi_d, hi_k);

    and u_out_l (out_l, lo, ns1);
    and u_out_h (out_h, hi, sel[1]);
    and u_out_k (out_k, lo, hi);
    or  u_out   (y[i], out_l, out_h, out_k);
  end

  // Pipeline copy for downstream clocked logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
    end else begin
      y_q <= y;
    end
  end

endmodule

// File: tb/tb_gmux_4way_16.sv
// Self-checking bench for gmux_4way_16: directed cases plus randomized
// traffic compared against an array-indexed reference model.
module tb_gmux_4way_16;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] a, b, c, d;
  logic [1:0]       sel;
  logic [WIDTH-1:0] y, y_q;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  gmux_4way_16 #(.WIDTH(WIDTH)) dut (
    .a(a), .b(b), .c(c), .d(d), .sel(sel),
    .y(y), .y_q(y_q), .clk(clk), .rst_n(rst_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_mux(input logic [1:0] s,
      input logic [WIDTH-1:0] wa, input logic [WIDTH-1:0] wb,
      input logic [WIDTH-1:0] wc, input logic [WIDTH-1:0] wd);
    logic [WIDTH-1:0] words [4];
    words[0] = wa;
    words[1] = wb;
    words[2] = wc;
    words[3] = wd;
    return words[s];
  endfunction

  initial begin
    logic [WIDTH-1:0] exp_y;
    logic [WIDTH-1:0] plan [4];

    rst_n = 1'b0;
    a = 16'h0000; b = 16'hFFFF; c = 16'hAAAA; d = 16'h5555;
    sel = 2'b00;
    #1;
    check("reset_yq", y_q, 16'h0000);

    // Combinational select, no clock dependence (reset held low).
    plan[0] = 16'h0000; plan[1] = 16'hFFFF; plan[2] = 16'hAAAA; plan[3] = 16'h5555;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #10;
      check($sformatf("sel_step%0d", s), y, plan[s]);
    end

    sel = 2'b10;
    c = 16'h1234;
    #0.001;
    check("c_follow", y, 16'h1234);
    a = 16'h7777; b = 16'h3C3C; d = 16'hDEAD;
    #1;
    check("others_quiet", y, 16'h1234);

    a = 16'h0000; b = 16'hFFFF; c = 16'hAAAA; d = 16'h5555;
    sel = 2'b01;
    @(posedge clk); #1;
    check("rst_clk_yq", y_q, 16'h0000);
    check("rst_y_valid", y, 16'hFFFF);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_load", y_q, 16'hFFFF);

    @(negedge clk); sel = 2'b00;
    @(posedge clk); #1;
    check("track_00", y_q, 16'h0000);
    @(negedge clk); sel = 2'b11;
    #1;
    check("lag_before_edge", y_q, 16'h0000);
    @(posedge clk); #1;
    check("track_11", y_q, 16'h5555);

    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", y_q, 16'h0000);
    check("async_y_kept", y, 16'h5555);
    @(negedge clk); rst_n = 1'b1;

    // Unknown select bit where candidates agree.
    a = 16'h00FF; c = 16'h00FF; b = 16'h0F0F; d = 16'h0F0F;
    sel = 2'bx0;
    #1;
    check("x_sel_agree", y, 16'h00FF);
    a = 16'h0000; b = 16'hFFFF;
    sel = 2'b0x;
    #2;

    // Randomized traffic with occasional reset pulses.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      a = 16'($urandom); b = 16'($urandom);
      c = 16'($urandom); d = 16'($urandom);
      sel = 2'($urandom_range(3));
      rst_n = ($urandom_range(15) != 0);
      exp_y = ref_mux(sel, a, b, c, d);
      #1;
      check("rand_y", y, exp_y);
      if (!rst_n) check("rand_rst_yq", y_q, 16'h0000);
      @(posedge clk); #1;
      check("rand_yq", y_q, rst_n ? exp_y : 16'h0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
